// File: rtl/alu_operand_stage.sv
// ID/EX operand register: forwards rs/rt, selects operand B and captures A, B and store data.
// Latency: one cycle from an accepted i_valid to o_valid.
// Backpressure: o_ready is low while EX stalls a held result or a load-use hazard is present.
`timescale 1ns/1ps
module alu_operand_stage #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [AW-1:0]    i_rs_addr,
    input  logic [AW-1:0]    i_rt_addr,
    input  logic [WIDTH-1:0] i_rs_data,
    input  logic [WIDTH-1:0] i_rt_data,
    input  logic             i_rt_used,
    input  logic [15:0]      i_imm16,
    input  logic [4:0]       i_shamt,
    input  logic [1:0]       i_bsel,
    input  logic             i_exm_wr_en,
    input  logic [AW-1:0]    i_exm_wr_addr,
    input  logic [WIDTH-1:0] i_exm_wr_data,
    input  logic             i_exm_is_load,
    input  logic             i_wb_wr_en,
    input  logic [AW-1:0]    i_wb_wr_addr,
    input  logic [WIDTH-1:0] i_wb_wr_data,
    input  logic             i_flush,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_op_a,
    output logic [WIDTH-1:0] o_op_b,
    output logic [WIDTH-1:0] o_store_data,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic             o_hazard
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
        logic [WIDTH-1:0] store;
        logic [1:0]       fwd_a;
        logic [1:0]       fwd_b;
    } opnd_t;

    opnd_t            opnd_d;
    opnd_t            opnd_q;
    logic             valid_q;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [WIDTH-1:0] fwd_a_dat;
    logic [WIDTH-1:0] fwd_b_dat;
    logic             exm_fwd_ok;
    logic             load_pending;
    logic             capture;

    // A load in EX/MEM has no data yet, so it can never be a forward source.
    assign exm_fwd_ok   = i_exm_wr_en && !i_exm_is_load;
    assign load_pending = i_exm_wr_en && i_exm_is_load && (i_exm_wr_addr != '0);

    always_comb begin
        fwd_a_sel = FWD_RF;
        fwd_a_dat = i_rs_data;
        if (i_rs_addr != '0) begin
            if (exm_fwd_ok && (i_exm_wr_addr == i_rs_addr)) begin
                fwd_a_sel = FWD_EXM;
                fwd_a_dat = i_exm_wr_data;
            end else if (i_wb_wr_en && (i_wb_wr_addr == i_rs_addr)) begin
                fwd_a_sel = FWD_WB;
                fwd_a_dat = i_wb_wr_data;
            end
        end
    end

    always_comb begin
        fwd_b_sel = FWD_RF;
        fwd_b_dat = i_rt_data;
        if (i_rt_addr != '0) begin
            if (exm_fwd_ok && (i_exm_wr_addr == i_rt_addr)) begin
                fwd_b_sel = FWD_EXM;
                fwd_b_dat = i_exm_wr_data;
            end else if (i_wb_wr_en && (i_wb_wr_addr == i_rt_addr)) begin
                fwd_b_sel = FWD_WB;
                fwd_b_dat = i_wb_wr_data;
            end
        end
    end

    always_comb begin
        opnd_d       = '0;
        opnd_d.op_a  = fwd_a_dat;
        opnd_d.store = fwd_b_dat;
        opnd_d.fwd_a = fwd_a_sel;
        opnd_d.fwd_b = fwd_b_sel;
        unique case (i_bsel)
            2'b00:   opnd_d.op_b = fwd_b_dat;
            2'b01:   opnd_d.op_b = {{(WIDTH-16){i_imm16[15]}}, i_imm16};
            2'b10:   opnd_d.op_b = {{(WIDTH-16){1'b0}}, i_imm16};
            default: opnd_d.op_b = {{(WIDTH-5){1'b0}}, i_shamt};
        endcase
    end

    assign o_hazard = i_valid && load_pending &&
                      ((i_exm_wr_addr == i_rs_addr) ||
                       (i_rt_used && (i_exm_wr_addr == i_rt_addr)));
    assign o_ready  = (!valid_q || i_ready) && !o_hazard;
    assign capture  = i_valid && o_ready;

    // Flush only kills the valid bit; the payload is don't-care once invalid.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            opnd_q  <= '0;
        end else if (i_flush) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q <= 1'b1;
            opnd_q  <= opnd_d;
        end else if (i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid      = valid_q;
    assign o_op_a       = opnd_q.op_a;
    assign o_op_b       = opnd_q.op_b;
    assign o_store_data = opnd_q.store;
    assign o_fwd_a      = opnd_q.fwd_a;
    assign o_fwd_b      = opnd_q.fwd_b;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table, hand sequences for multi-cycle cases,
// then randomized traffic against a spec-level reference model.
`timescale 1ns/1ps
module tb_alu_operand_stage;

    logic        i_clk, i_rst, i_valid, o_ready;
    logic [4:0]  i_rs_addr, i_rt_addr;
    logic [31:0] i_rs_data, i_rt_data;
    logic        i_rt_used;
    logic [15:0] i_imm16;
    logic [4:0]  i_shamt;
    logic [1:0]  i_bsel;
    logic        i_exm_wr_en;
    logic [4:0]  i_exm_wr_addr;
    logic [31:0] i_exm_wr_data;
    logic        i_exm_is_load;
    logic        i_wb_wr_en;
    logic [4:0]  i_wb_wr_addr;
    logic [31:0] i_wb_wr_data;
    logic        i_flush, i_ready, o_valid;
    logic [31:0] o_op_a, o_op_b, o_store_data;
    logic [1:0]  o_fwd_a, o_fwd_b;
    logic        o_hazard;

    alu_operand_stage #(.WIDTH(32), .AW(5)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr),
        .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_rt_used(i_rt_used),
        .i_imm16(i_imm16), .i_shamt(i_shamt), .i_bsel(i_bsel),
        .i_exm_wr_en(i_exm_wr_en), .i_exm_wr_addr(i_exm_wr_addr),
        .i_exm_wr_data(i_exm_wr_data), .i_exm_is_load(i_exm_is_load),
        .i_wb_wr_en(i_wb_wr_en), .i_wb_wr_addr(i_wb_wr_addr), .i_wb_wr_data(i_wb_wr_data),
        .i_flush(i_flush), .i_ready(i_ready), .o_valid(o_valid),
        .o_op_a(o_op_a), .o_op_b(o_op_b), .o_store_data(o_store_data),
        .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b), .o_hazard(o_hazard)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  rs, rt;
        logic [31:0] rs_d, rt_d;
        logic        rt_used;
        logic [15:0] imm;
        logic [4:0]  shamt;
        logic [1:0]  bsel;
        logic        exm_en;
        logic [4:0]  exm_a;
        logic [31:0] exm_d;
        logic        exm_ld;
        logic        wb_en;
        logic [4:0]  wb_a;
        logic [31:0] wb_d;
        logic        hz;
        logic [31:0] a, b, st;
        logic [1:0]  fa, fb;
    } vec_t;

    vec_t vecs[10];

    task automatic clear_inputs();
        i_valid = 0; i_rs_addr = 0; i_rt_addr = 0; i_rs_data = 0; i_rt_data = 0;
        i_rt_used = 0; i_imm16 = 0; i_shamt = 0; i_bsel = 0;
        i_exm_wr_en = 0; i_exm_wr_addr = 0; i_exm_wr_data = 0; i_exm_is_load = 0;
        i_wb_wr_en = 0; i_wb_wr_addr = 0; i_wb_wr_data = 0; i_flush = 0; i_ready = 1;
    endtask

    task automatic drive_vec(input vec_t v);
        i_rs_addr = v.rs; i_rt_addr = v.rt; i_rs_data = v.rs_d; i_rt_data = v.rt_d;
        i_rt_used = v.rt_used; i_imm16 = v.imm; i_shamt = v.shamt; i_bsel = v.bsel;
        i_exm_wr_en = v.exm_en; i_exm_wr_addr = v.exm_a; i_exm_wr_data = v.exm_d;
        i_exm_is_load = v.exm_ld; i_wb_wr_en = v.wb_en; i_wb_wr_addr = v.wb_a;
        i_wb_wr_data = v.wb_d;
    endtask

    // Reference model: resolve a source register from the spec's priority rules.
    task automatic resolve(input logic [4:0] addr, input logic [31:0] rf,
                           output logic [1:0] code, output logic [31:0] data);
        code = 2'b00;
        data = rf;
        if (addr != 0) begin
            if (i_wb_wr_en && i_wb_wr_addr == addr) begin
                code = 2'b10; data = i_wb_wr_data;
            end
            if (i_exm_wr_en && !i_exm_is_load && i_exm_wr_addr == addr) begin
                code = 2'b01; data = i_exm_wr_data;
            end
        end
    endtask

    logic        mv;
    logic [31:0] ma, mb, ms;
    logic [1:0]  mfa, mfb;

    initial begin
        logic        exp_hz, exp_rdy;
        logic [1:0]  ca, cb;
        logic [31:0] da, db, bval;

        //             rs rt rs_d        rt_d        u  imm       sh bsel en a  exm_d        ld wb a  wb_d         hz a            b             st            fa     fb
        vecs[0] = '{3, 7, 32'h33,     32'h77,     1, 16'h0000, 0, 2'b00, 1, 3, 32'h11,     0, 1, 3, 32'h22,     0, 32'h11,     32'h77,       32'h77,     2'b01, 2'b00};
        vecs[1] = '{3, 7, 32'h33,     32'h77,     1, 16'h0000, 0, 2'b00, 0, 3, 32'h11,     0, 1, 3, 32'h22,     0, 32'h22,     32'h77,       32'h77,     2'b10, 2'b00};
        vecs[2] = '{3, 7, 32'h33,     32'h77,     1, 16'h0000, 0, 2'b00, 0, 3, 32'h11,     0, 0, 3, 32'h22,     0, 32'h33,     32'h77,       32'h77,     2'b00, 2'b00};
        vecs[3] = '{0, 0, 32'h55,     32'h66,     1, 16'h0000, 0, 2'b00, 1, 0, 32'hFFFF,   0, 1, 0, 32'h1234,   0, 32'h55,     32'h66,       32'h66,     2'b00, 2'b00};
        vecs[4] = '{1, 6, 32'h10,     32'h66,     1, 16'h8001, 5, 2'b01, 0, 0, 32'h0,      0, 1, 6, 32'h99,     0, 32'h10,     32'hFFFF8001, 32'h99,     2'b00, 2'b10};
        vecs[5] = '{1, 6, 32'h10,     32'h66,     1, 16'h8001, 5, 2'b10, 1, 6, 32'hAA,     0, 1, 6, 32'h99,     0, 32'h10,     32'h00008001, 32'hAA,     2'b00, 2'b01};
        vecs[6] = '{1, 6, 32'h10,     32'h66,     1, 16'h8001, 5, 2'b11, 0, 6, 32'hAA,     0, 0, 6, 32'h99,     0, 32'h10,     32'h00000005, 32'h66,     2'b00, 2'b00};
        vecs[7] = '{1, 4, 32'h10,     32'h44,     0, 16'h0000, 0, 2'b00, 1, 4, 32'hDEAD,   1, 0, 0, 32'h0,      0, 32'h10,     32'h44,       32'h44,     2'b00, 2'b00};
        vecs[8] = '{1, 4, 32'h10,     32'h44,     1, 16'h0000, 0, 2'b00, 1, 4, 32'hDEAD,   1, 0, 0, 32'h0,      1, 32'h0,      32'h0,        32'h0,      2'b00, 2'b00};
        vecs[9] = '{0, 0, 32'h21,     32'h22,     1, 16'h0000, 0, 2'b00, 1, 0, 32'hBEEF,   1, 0, 0, 32'h0,      0, 32'h21,     32'h22,       32'h22,     2'b00, 2'b00};

        clear_inputs();
        i_rst = 1;
        #12;
        check("reset_valid", {31'd0, o_valid}, 32'd0);
        check("reset_op_a", o_op_a, 32'd0);
        check("reset_op_b", o_op_b, 32'd0);
        check("reset_store", o_store_data, 32'd0);
        check("reset_fwd", {28'd0, o_fwd_a, o_fwd_b}, 32'd0);
        @(negedge i_clk);
        i_rst = 0;

        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            drive_vec(vecs[i]);
            i_valid = 1;
            #1;
            check($sformatf("vec%0d_hazard", i), {31'd0, o_hazard}, {31'd0, vecs[i].hz});
            check($sformatf("vec%0d_ready", i), {31'd0, o_ready}, {31'd0, !vecs[i].hz});
            @(posedge i_clk);
            #1;
            check($sformatf("vec%0d_valid", i), {31'd0, o_valid}, {31'd0, !vecs[i].hz});
            if (!vecs[i].hz) begin
                check($sformatf("vec%0d_op_a", i), o_op_a, vecs[i].a);
                check($sformatf("vec%0d_op_b", i), o_op_b, vecs[i].b);
                check($sformatf("vec%0d_store", i), o_store_data, vecs[i].st);
                check($sformatf("vec%0d_fwd_a", i), {30'd0, o_fwd_a}, {30'd0, vecs[i].fa});
                check($sformatf("vec%0d_fwd_b", i), {30'd0, o_fwd_b}, {30'd0, vecs[i].fb});
            end
        end

        // Load-use: stall one cycle, then pick the load result up from MEM/WB.
        @(negedge i_clk);
        clear_inputs();
        i_valid = 1; i_rs_addr = 4; i_rs_data = 32'h1111;
        i_exm_wr_en = 1; i_exm_wr_addr = 4; i_exm_is_load = 1;
        #1;
        check("lu_hazard", {31'd0, o_hazard}, 32'd1);
        check("lu_ready", {31'd0, o_ready}, 32'd0);
        @(posedge i_clk); #1;
        check("lu_no_capture", {31'd0, o_valid}, 32'd0);
        @(negedge i_clk);
        i_exm_wr_en = 0; i_exm_is_load = 0;
        i_wb_wr_en = 1; i_wb_wr_addr = 4; i_wb_wr_data = 32'hABCD;
        #1;
        check("lu_clear_hazard", {31'd0, o_hazard}, 32'd0);
        @(posedge i_clk); #1;
        check("lu_valid", {31'd0, o_valid}, 32'd1);
        check("lu_op_a", o_op_a, 32'hABCD);
        check("lu_fwd_a", {30'd0, o_fwd_a}, 32'd2);

        // Backpressure: held output stays put for three stalled cycles.
        @(negedge i_clk);
        clear_inputs();
        i_valid = 1; i_ready = 0; i_rs_addr = 5; i_rs_data = 32'h5555;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp%0d_ready", c), {31'd0, o_ready}, 32'd0);
            @(posedge i_clk); #1;
            check($sformatf("bp%0d_valid", c), {31'd0, o_valid}, 32'd1);
            check($sformatf("bp%0d_op_a", c), o_op_a, 32'hABCD);
            check($sformatf("bp%0d_fwd_a", c), {30'd0, o_fwd_a}, 32'd2);
            @(negedge i_clk);
        end
        i_ready = 1;
        #1;
        check("bp_release_ready", {31'd0, o_ready}, 32'd1);
        @(posedge i_clk); #1;
        check("bp_release_op_a", o_op_a, 32'h5555);
        check("bp_release_fwd_a", {30'd0, o_fwd_a}, 32'd0);

        // Flush beats a simultaneous capture.
        @(negedge i_clk);
        i_valid = 1; i_flush = 1; i_rs_data = 32'h7777;
        #1;
        check("flush_ready", {31'd0, o_ready}, 32'd1);
        @(posedge i_clk); #1;
        check("flush_valid", {31'd0, o_valid}, 32'd0);

        // Reset mid-cycle while holding a valid result.
        @(negedge i_clk);
        i_flush = 0; i_valid = 1; i_rs_data = 32'h9999; i_bsel = 2'b11; i_shamt = 5'd9;
        @(posedge i_clk); #1;
        check("pre_rst_valid", {31'd0, o_valid}, 32'd1);
        #2;
        i_rst = 1;
        #1;
        check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        check("mid_rst_op_a", o_op_a, 32'd0);
        check("mid_rst_op_b", o_op_b, 32'd0);
        check("mid_rst_store", o_store_data, 32'd0);
        @(negedge i_clk);
        i_rst = 0; i_valid = 0;
        repeat (2) @(posedge i_clk);
        #1;
        check("post_rst_idle", {31'd0, o_valid}, 32'd0);

        // Randomized traffic against the reference model.
        mv = 0; ma = 0; mb = 0; ms = 0; mfa = 0; mfb = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge i_clk);
            check("rnd_valid", {31'd0, o_valid}, {31'd0, mv});
            if (mv) begin
                check("rnd_op_a", o_op_a, ma);
                check("rnd_op_b", o_op_b, mb);
                check("rnd_store", o_store_data, ms);
                check("rnd_fwd", {28'd0, o_fwd_a, o_fwd_b}, {28'd0, mfa, mfb});
            end
            i_valid       = ($urandom_range(0, 3) != 0);
            i_rs_addr     = 5'($urandom_range(0, 3));
            i_rt_addr     = 5'($urandom_range(0, 3));
            i_rs_data     = $urandom;
            i_rt_data     = $urandom;
            i_rt_used     = 1'($urandom_range(0, 1));
            i_imm16       = 16'($urandom);
            i_shamt       = 5'($urandom);
            i_bsel        = 2'($urandom);
            i_exm_wr_en   = 1'($urandom_range(0, 1));
            i_exm_wr_addr = 5'($urandom_range(0, 3));
            i_exm_wr_data = $urandom;
            i_exm_is_load = ($urandom_range(0, 2) == 0);
            i_wb_wr_en    = 1'($urandom_range(0, 1));
            i_wb_wr_addr  = 5'($urandom_range(0, 3));
            i_wb_wr_data  = $urandom;
            i_flush       = ($urandom_range(0, 9) == 0);
            i_ready       = ($urandom_range(0, 3) != 0);
            #1;
            exp_hz = i_valid && i_exm_wr_en && i_exm_is_load && i_exm_wr_addr != 0 &&
                     (i_exm_wr_addr == i_rs_addr || (i_rt_used && i_exm_wr_addr == i_rt_addr));
            exp_rdy = (!mv || i_ready) && !exp_hz;
            check("rnd_hazard", {31'd0, o_hazard}, {31'd0, exp_hz});
            check("rnd_ready", {31'd0, o_ready}, {31'd0, exp_rdy});
            resolve(i_rs_addr, i_rs_data, ca, da);
            resolve(i_rt_addr, i_rt_data, cb, db);
            case (i_bsel)
                2'b00:   bval = db;
                2'b01:   bval = (i_imm16 >= 16'h8000) ? (32'hFFFF0000 + i_imm16) : 32'(i_imm16);
                2'b10:   bval = 32'(i_imm16);
                default: bval = 32'(i_shamt);
            endcase
            if (i_flush) begin
                mv = 0;
            end else if (i_valid && exp_rdy) begin
                mv = 1; ma = da; mb = bval; ms = db; mfa = ca; mfb = cb;
            end else if (i_ready) begin
                mv = 0;
            end
            @(posedge i_clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
